cla_mul_seq: RTL and testbench
==============================

// Module: cla_mul_seq
//
// PURPOSE
//   Iterative unsigned shift-and-add multiplier built on one shared N-bit CLA
//   instance (ADD_SUB tied 0). It produces an N x N -> 2N product in N step
//   cycles, with a START/BUSY/DONE handshake.
//   It sits between the term-project control logic and the adder datapath, so
//   multiply reuses existing adder hardware instead of an array multiplier.
//
// PARAMETERS
//   N   32   operand width; legal N >= 2; product width 2N
//
// PORTS
//   CLK    in   1    single clock, all state on rising edge
//   RST    in   1    asynchronous, active-high reset
//   START  in   1    request; sampled only when state is IDLE or DONE
//   A      in   N    multiplicand, captured on accepting edge
//   B      in   N    multiplier, captured on accepting edge
//   P      out  2N   product register; valid while DONE=1, held until next accept
//   BUSY   out  1    1 while in RUN
//   DONE   out  1    1-cycle pulse: P holds the final product
//
// BEHAVIOUR
// - Reset (RST=1, any time, async): state=IDLE, P=0, BUSY=0, DONE=0, count=0,
//   internal operand regs=0. Reset mid-RUN abandons the operation; no DONE.
// - States: IDLE, RUN, DONE.
//   IDLE : START=1 -> RUN (accept). START=0 -> stay.
//   RUN  : one step per edge; after the N-th step -> DONE.
//   DONE : START=1 -> RUN (back-to-back accept, no idle bubble);
//          START=0 -> IDLE.
// - Accepting edge: MCAND<=A; P<={N'b0, B}; count<=0. A/B are ignored afterwards.
//   Changing A/B during RUN has no effect.
// - Step (RUN edge), using CLA with A=P[2N-1:N], B=MCAND, ADD_SUB=0 -> {COUT,SUM}:
//     if P[0]=1 : P <= {COUT, SUM, P[N-1:1]}
//     else      : P <= {1'b0, P[2N-1:N], P[N-1:1]}
//     count <= count+1. Leave RUN when count==N-1 at the edge.
//   The carry never exceeds 2N bits, so there is no overflow output.
// - Latency: DONE=1 in the cycle after the N-th edge following the accepting
//   edge (exactly N edges). START at edge t0 -> DONE high for the cycle starting
//   at t0+N.
// - BUSY = (state==RUN); DONE = (state==DONE); both are registered-state decodes.
// - START while BUSY=1 is ignored; it is not queued.
// - P is not cleared on DONE->IDLE. It holds the last product until the next
//   accept or reset.
// - Counter width: $clog2(N)+1 bits. The counter wraps are never reached.
// - Zero operands take the full N cycles; there is no early termination.
//
// TESTING
//   1. N=32, A=3, B=5, START 1 cycle -> BUSY 32 cycles, DONE pulse at t0+32,
//      P=64'h0F.
//   2. A=B=32'hFFFFFFFF -> P=64'hFFFFFFFE00000001. Checks the COUT path on
//      every step.
//   3. A=32'h12345678, B=0 and A=0, B=32'hDEADBEEF -> P=0 after 32 cycles.
//      DONE is still at t0+32.
//   4. Start A=7, B=9. Mid-RUN, pulse START with A=B=2 and toggle A/B
//      -> P=63. Only one DONE.
//   5. Hold START=1 through DONE with new A=10, B=10 -> DONE(63) then RUN
//      immediately. Second DONE 32 edges later, P=100.
//   6. Assert RST at cycle 10 of RUN (async, mid-cycle) -> P=0, BUSY=0, DONE=0
//      at once. No DONE follows. A fresh START 6*7 -> P=42.

Source files
------------

// File: rtl/cla_mul_seq.sv
//==============================================================================
// Module      : cla_mul_seq (with helper cla_adder)
// Description : Iterative unsigned shift-and-add multiplier. One shared N-bit
//               carry-lookahead adder performs every partial-product add, so
//               an N x N -> 2N product takes N step cycles after acceptance.
// Ports       :
//   clk_i    in   1    clock, all state on the rising edge
//   rst_i    in   1    asynchronous active-high reset
//   start_i  in   1    request, sampled only in IDLE or DONE
//   a_i      in   N    multiplicand, captured on the accepting edge
//   b_i      in   N    multiplier, captured on the accepting edge
//   p_o      out  2N   product register, valid while done_o=1, held until
//                      the next accept or reset
//   busy_o   out  1    high while the multiply is running
//   done_o   out  1    one-cycle pulse, p_o holds the final product
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

//------------------------------------------------------------------------------
// cla_adder : N-bit carry-lookahead adder/subtractor. Carries come from a
// parallel-prefix (Kogge-Stone) combine of per-bit generate/propagate.
//------------------------------------------------------------------------------
module cla_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         add_sub_i,   // 0: a+b, 1: a-b (two's complement)
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    localparam int LEVELS = $clog2(N);

    logic [N-1:0] w_bx;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_gg;
    logic [N-1:0] w_pp;
    logic [N-1:0] w_ones;
    logic [N:0]   w_c;

    always_comb begin
        w_bx   = b_i ^ {N{add_sub_i}};
        w_g    = a_i & w_bx;
        w_p    = a_i ^ w_bx;
        w_ones = '1;
        w_gg   = w_g;
        w_pp   = w_p;
        // Each level folds in the (g,p) pair 2^k positions below. Bits below
        // the span keep their value: shifted-in generate is 0 and the
        // shifted-in propagate is forced to 1.
        for (int k = 0; k < LEVELS; k++) begin
            w_gg = w_gg | (w_pp & (w_gg << (1 << k)));
            w_pp = w_pp & ((w_pp << (1 << k)) | ~(w_ones << (1 << k)));
        end
        w_c[0]   = add_sub_i;
        w_c[N:1] = w_gg | (w_pp & {N{add_sub_i}});
        sum_o    = w_p ^ w_c[N-1:0];
        cout_o   = w_c[N];
    end

endmodule

//------------------------------------------------------------------------------
// cla_mul_seq : sequential shift-and-add multiplier around cla_adder.
//------------------------------------------------------------------------------
module cla_mul_seq #(
    parameter int N = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]  count_q, count_d;

    logic [N-1:0]   w_sum;
    logic           w_cout;

    // Upper half of the product accumulates; the multiplicand is added in.
    cla_adder #(.N(N)) u_cla (
        .a_i       (p_q[2*N-1:N]),
        .b_i       (mcand_q),
        .add_sub_i (1'b0),
        .sum_o     (w_sum),
        .cout_o    (w_cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mcand_d = mcand_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts directly so back-to-back operations have no
                // idle bubble; P is otherwise left untouched.
                if (start_i) begin
                    state_d = ST_RUN;
                    mcand_d = a_i;
                    p_d     = {{N{1'b0}}, b_i};
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Multiplier bits are consumed from P[0] as the whole
                // register shifts right; the carry-out becomes the new MSB.
                if (p_q[0]) begin
                    p_d = {w_cout, w_sum, p_q[N-1:1]};
                end else begin
                    p_d = {1'b0, p_q[2*N-1:N], p_q[N-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign p_o    = p_q;
    assign busy_o = (state_q == ST_RUN);
    assign done_o = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cla_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none

module tb_cla_mul_seq;

    localparam int N = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
    logic           busy;
    logic           done;

    int tests_run    = 0;
    int tests_failed = 0;

    cla_mul_seq #(.N(N)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .p_o     (p),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepts one operation, drops START, then waits (bounded) for DONE.
    // lat = edges from the accepting edge to DONE; bcnt = busy samples.
    task automatic do_mul(input logic [N-1:0] av, input logic [N-1:0] bv,
                          output int lat, output int bcnt,
                          output logic [2*N-1:0] pv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        bcnt = busy ? 1 : 0;
        lat  = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        pv = p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (p !== 64'h0) begin tests_failed++; $display("FAIL reset_p got=%h exp=0", p); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic [2*N-1:0] pv;
        do_mul(32'd3, 32'd5, lat, bcnt, pv);
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=32", lat); end
        tests_run++;
        if (bcnt !== 32) begin tests_failed++; $display("FAIL basic_busy_cycles got=%0d exp=32", bcnt); end
        tests_run++;
        if (pv !== 64'h0F) begin tests_failed++; $display("FAIL basic_product got=%h exp=%h", pv, 64'h0F); end
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (p !== 64'h0F) begin tests_failed++; $display("FAIL basic_p_held got=%h exp=%h", p, 64'h0F); end
    endtask

    task automatic test_max();
        int lat, bcnt;
        logic [2*N-1:0] pv;
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, pv);
        tests_run++;
        if (pv !== 64'hFFFFFFFE00000001) begin
            tests_failed++;
            $display("FAIL max_product got=%h exp=%h", pv, 64'hFFFFFFFE00000001);
        end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL max_latency got=%0d exp=32", lat); end
    endtask

    task automatic test_zero();
        int lat, bcnt;
        logic [2*N-1:0] pv;
        do_mul(32'h12345678, 32'h0, lat, bcnt, pv);
        tests_run++;
        if (pv !== 64'h0 || lat !== 32) begin
            tests_failed++;
            $display("FAIL zero_b got p=%h lat=%0d exp p=0 lat=32", pv, lat);
        end
        do_mul(32'h0, 32'hDEADBEEF, lat, bcnt, pv);
        tests_run++;
        if (pv !== 64'h0 || lat !== 32) begin
            tests_failed++;
            $display("FAIL zero_a got p=%h lat=%0d exp p=0 lat=32", pv, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int dcnt;
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        // Wiggle the operands while running; they must be ignored.
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            @(negedge clk);
            a = $urandom;
            b = $urandom;
        end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL busy_start_latency got=%0d exp=32", lat); end
        tests_run++;
        if (p !== 64'd63) begin tests_failed++; $display("FAIL busy_start_product got=%0d exp=63", p); end
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        tests_run++;
        if (dcnt !== 0) begin tests_failed++; $display("FAIL busy_start_queued got=%0d extra cycles exp=0", dcnt); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        a = 32'd10; b = 32'd10;   // START stays high through RUN and DONE
        lat = 0;
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        tests_run++;
        if (lat !== 32 || p !== 64'd63) begin
            tests_failed++;
            $display("FAIL b2b_first got lat=%0d p=%0d exp lat=32 p=63", lat, p);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_bubble got busy=%b done=%b exp 1 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        tests_run++;
        if (lat !== 32 || p !== 64'd100) begin
            tests_failed++;
            $display("FAIL b2b_second got lat=%0d p=%0d exp lat=32 p=100", lat, p);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt, dcnt;
        logic [2*N-1:0] pv;
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (p !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got p=%h busy=%b done=%b exp 0 0 0", p, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        tests_run++;
        if (dcnt !== 0) begin tests_failed++; $display("FAIL reset_abandon got=%0d active cycles exp=0", dcnt); end
        do_mul(32'd6, 32'd7, lat, bcnt, pv);
        tests_run++;
        if (pv !== 64'd42 || lat !== 32) begin
            tests_failed++;
            $display("FAIL after_reset got p=%0d lat=%0d exp p=42 lat=32", pv, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
